chan_mux_rr: RTL
================

Name: chan_mux_rr

Overview:
Parametrised, registered N-channel word multiplexer; successor to the 32-bit 3-to-1 combinational mux. Each input channel has a valid/ready handshake. The block either forwards the channel chosen by sel (fixed mode) or arbitrates round-robin among valid channels (RR mode). The chosen word is registered into a single-entry output stage, tagged with its source channel, and sits between datapath sources and a downstream register/ALU stage.

Parameters:
WIDTH, 32, data word width in bits
NCH, 3, number of input channels (2..16)
SELW, 2, width of sel and out_ch; must satisfy 2**SELW >= NCH

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select by sel, 1 = round-robin
sel  input  SELW  channel index used in fixed mode
in_valid  input  NCH  per-channel data valid
in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  NCH  per-channel accept; at most one bit high
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered word
out_ch  output  SELW  source channel of out_data
out_ready  input  1  downstream accept

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, RR pointer=NCH-1, so channel 0 has first priority. Reset during any operation discards the held word; in_ready is 0 in the reset cycle.
- can_load = !out_valid || out_ready. The output stage is one entry and supports full-throughput back-to-back transfers.
- Grant, combinational from the current inputs:
  - Fixed mode: grant = sel when sel < NCH and in_valid[sel]=1; otherwise no grant. sel >= NCH never grants and is not an error.
  - RR mode: scan channels ptr+1, ptr+2, ... mod NCH; the first with in_valid=1 wins; no valid channel means no grant.
- in_ready[i] = can_load && grant==i && !reset. in_ready depends on the grant; in_valid must not depend on in_ready.
- Transfer on channel i happens when in_valid[i] && in_ready[i]. On the next edge: out_data <= channel i word, out_ch <= i, out_valid <= 1.
- When can_load && no grant: out_valid <= 0 if out_ready=1; out_data and out_ch hold their values.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid hold; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- RR pointer updates to i only on a transfer in RR mode. Fixed-mode transfers leave it unchanged. If only one channel is valid, that channel receives every slot.
- A mode or sel change is seen only by the next grant. A word already in the output register is unaffected.
- Channel widths are exact; there is no truncation or extension. out_ch is the zero-extended channel index.

Optional Feature:
CHAN_MUX_PARITY_EN
- Defined: adds output out_par (1 bit) = ^out_data, registered with out_data and cleared to 0 on reset. It updates and holds under exactly the same conditions as out_data.
- Undefined: port out_par and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then fixed mode with in_data ch0=76, ch1=90, ch2=555, all valid, out_ready=1, sel=0 → next cycle out_valid=1, out_data=76, out_ch=0; sel=1 → 90/1; sel=2 → 555/2.
- Fixed mode, sel=3 (NCH=3), all valid → in_ready=000, out_valid falls to 0 one cycle later, out_data holds 555.
- RR mode, all three valid continuously, out_ready=1 → out_ch sequence 0,1,2,0,1,2; with ch1 invalid → 0,2,0,2.
- Stall: out_valid=1 with out_data=9999999, out_ready=0 for 3 cycles while ch2 changes to 1023 → out_data stays 9999999, in_ready=000; out_ready=1 → the next word 1023 appears the following cycle.
- Reset asserted while out_valid=1 holding 23322 → next cycle out_valid=0, out_data=0, out_ch=0; first RR grant after reset goes to channel 0.
- With CHAN_MUX_PARITY_EN defined: out_data=7 → out_par=1; out_data=90 → out_par=0.

Source files
------------

// File: rtl/chan_mux_rr.sv
// Registered N-channel word mux with valid/ready inputs: fixed select or round-robin arbitration.
// Optional out_par (registered ^out_data) is present when CHAN_MUX_PARITY_EN is defined.
module chan_mux_rr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 3,
  parameter int unsigned SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
`ifdef CHAN_MUX_PARITY_EN
  output logic                 out_par,
`endif
  input  logic                 out_ready
);

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SELW-1:0]   out_ch_q;
  logic [SELW-1:0]   ptr_q;
  logic              can_load;
  logic              xfer;

  logic              fix_valid;
  logic [SELW-1:0]   fix_gnt;
  logic              rr_valid;
  logic [SELW-1:0]   rr_gnt;
  logic [2*NCH-1:0]  rr_dbl;
  logic [NCH-1:0]    rr_rot;
  int                rr_off;
  int                rr_idx;

  logic              gnt_valid;
  logic [SELW-1:0]   gnt;
  logic [WIDTH-1:0]  gnt_word;

  assign can_load = !out_valid_q || out_ready;

  // Fixed mode: an out-of-range sel simply matches no channel.
  always_comb begin
    fix_valid = 1'b0;
    fix_gnt   = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (sel == SELW'(i) && in_valid[i]) begin
        fix_valid = 1'b1;
        fix_gnt   = SELW'(i);
      end
    end
  end

  // Rotate so bit 0 is channel ptr+1; the lowest set bit is the round-robin winner.
  assign rr_dbl = {in_valid, in_valid} >> (ptr_q + 1'b1);
  assign rr_rot = rr_dbl[NCH-1:0];

  always_comb begin
    rr_valid = 1'b0;
    rr_off   = 0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (rr_rot[i]) begin
        rr_valid = 1'b1;
        rr_off   = i;
      end
    end
    rr_idx = int'(ptr_q) + 1 + rr_off;
    if (rr_idx >= int'(NCH)) begin
      rr_idx = rr_idx - int'(NCH);
    end
    rr_gnt = SELW'(rr_idx);
  end

  assign gnt_valid = mode ? rr_valid : fix_valid;
  assign gnt       = mode ? rr_gnt   : fix_gnt;

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (gnt == SELW'(i)) begin
        gnt_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      in_ready[i] = can_load && gnt_valid && !reset && (gnt == SELW'(i));
    end
  end

  assign xfer = can_load && gnt_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(NCH - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_word;
      out_ch_q    <= gnt;
      if (mode) begin
        ptr_q <= gnt;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef CHAN_MUX_PARITY_EN
  logic out_par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_par_q <= 1'b0;
    end else if (xfer) begin
      out_par_q <= ^gnt_word;
    end
  end

  assign out_par = out_par_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifndef SYNTHESIS
  a_ready_onehot : assert property (@(posedge clk) $onehot0(in_ready));
  a_stall_hold : assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));
`endif

endmodule
